uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO feeding a UART transmitter. Bytes are enqueued on wr_en and
//   handed one at a time to the transmitter through a tx_start pulse. The
//   transmitter then reports activity on tx_busy.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   wr_data  in   8   byte to enqueue
//   wr_en    in   1   enqueue request
//   full     out  1   count == DEPTH
//   empty    out  1   count == 0
//   count    out  AW+1 bytes currently stored
//   overflow out  1   one-cycle pulse after a dropped write
//   tx_data  out  8   byte presented to the transmitter
//   tx_start out  1   one-cycle start pulse
//   tx_busy  in   1   transmitter busy flag
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 4,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy
);

  // Timer only has to count 0 .. BUSY_TIMEOUT-1.
  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  // Storage is not reset; only pointers and count define validity.
  logic [7:0]    mem_q [DEPTH];

  state_t        state_q,    state_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_data_q,  tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic [TW-1:0] timer_q,    timer_d;

  logic          full_c;
  logic          empty_c;
  logic          push;
  logic          pop;

  // Flags come from the registered count, so a write while full is
  // dropped even if a pop happens on the same edge.
  always_comb begin
    full_c  = (count_q == DEPTH_CNT);
    empty_c = (count_q == '0);
    push    = wr_en && !full_c;
  end

  // Transmit sequencing
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_c && !tx_busy) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TIMER_LAST) begin
          // Transmitter never acknowledged: the byte is considered sent.
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered start pulse: high exactly while the FSM sits in START.
    tx_start_d = (state_d == ST_START);
  end

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    overflow_d = wr_en && full_c;
    tx_data_d  = pop  ? mem_q[rd_ptr_q] : tx_data_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timer_q    <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_c;
  assign empty    = empty_c;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed scenarios with hand-computed
// expectations and a simple transmitter busy model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned AW           = 4;
  localparam int unsigned BUSY_TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .AW(AW),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy)
  );

  // Transmitter model: busy rises one cycle after tx_start, lasts 10 cycles.
  logic        model_en   = 1'b1;
  logic        busy_force = 1'b0;
  int unsigned model_cnt  = 0;

  always @(posedge clk) begin
    if (model_en && tx_start) model_cnt <= 10;
    else if (model_cnt != 0)  model_cnt <= model_cnt - 1;
  end

  assign tx_busy = model_en ? (model_cnt != 0) : busy_force;

  // Capture every start pulse and note any that coincide with busy.
  logic [7:0]  cap_q [$];
  int unsigned viol = 0;

  always @(negedge clk) begin
    if (tx_start) begin
      cap_q.push_back(tx_data);
      if (tx_busy) viol++;
    end
  end

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0;
    model_en = 1'b1; busy_force = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL rst_empty got %b want 1", empty); end
    tests++; if (full !== 1'b0)     begin fails++; $display("FAIL rst_full got %b want 0", full); end
    tests++; if (count !== '0)      begin fails++; $display("FAIL rst_count got %0d want 0", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow got %b want 0", overflow); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int unsigned base = cap_q.size();
    wr_data = 8'h8C; wr_en = 1'b1;
    @(negedge clk);                    // edge k wrote the byte
    wr_en = 1'b0;
    tests++; if (count !== 5'd1)    begin fails++; $display("FAIL single_count got %0d want 1", count); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_early_start got %b want 0", tx_start); end
    @(negedge clk);                    // edge k+1 popped it
    tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL single_start got %b want 1", tx_start); end
    tests++; if (tx_data !== 8'h8C) begin fails++; $display("FAIL single_data got %h want 8c", tx_data); end
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL single_empty got %b want 1", empty); end
    @(negedge clk);
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_pulse_width got %b want 0", tx_start); end
    tests++; if (tx_busy !== 1'b1)  begin fails++; $display("FAIL single_busy got %b want 1", tx_busy); end
    repeat (16) @(negedge clk);
    tests++; if (cap_q.size() - base !== 1) begin fails++; $display("FAIL single_start_count got %0d want 1", cap_q.size() - base); end
    tests++; if (tx_data !== 8'h8C) begin fails++; $display("FAIL single_data_hold got %h want 8c", tx_data); end
  endtask

  task automatic test_fill_overflow();
    int unsigned base = cap_q.size();
    busy_force = 1'b1; model_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i + 1); wr_en = 1'b1;
      @(negedge clk);
    end
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_count got %0d want 16", count); end
    tests++; if (full !== 1'b1)   begin fails++; $display("FAIL fill_full got %b want 1", full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_no_ovf got %b want 0", overflow); end
    wr_data = 8'hFF; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse got %b want 1", overflow); end
    tests++; if (count !== 5'd16)   begin fails++; $display("FAIL ovf_count got %0d want 16", count); end
    @(negedge clk);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_one_cycle got %b want 0", overflow); end
    tests++; if (cap_q.size() - base !== 0) begin fails++; $display("FAIL fill_no_start got %0d want 0", cap_q.size() - base); end
  endtask

  task automatic test_drain();
    int unsigned base = cap_q.size();
    int unsigned v0   = viol;
    int unsigned c    = 0;
    logic [7:0]  exp_b;
    model_en = 1'b1; busy_force = 1'b0;
    while (cap_q.size() - base < 16 && c < 400) begin @(negedge clk); c++; end
    repeat (16) @(negedge clk);
    tests++; if (cap_q.size() - base !== 16) begin fails++; $display("FAIL drain_starts got %0d want 16", cap_q.size() - base); end
    tests++; if (viol - v0 !== 0) begin fails++; $display("FAIL drain_start_while_busy got %0d want 0", viol - v0); end
    tests++; if (empty !== 1'b1)  begin fails++; $display("FAIL drain_empty got %b want 1", empty); end
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(i + 1);
      if (base + i < cap_q.size()) begin
        tests++;
        if (cap_q[base + i] !== exp_b) begin fails++; $display("FAIL drain_byte[%0d] got %h want %h", i, cap_q[base + i], exp_b); end
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned base;
    int unsigned c = 0;
    logic [7:0]  exp_b;
    wr_data = 8'h20; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    while (tx_busy !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL wrap_busy_rise got %b want 1", tx_busy); end
    repeat (2) @(negedge clk);         // FSM now in WAIT_DONE
    busy_force = 1'b1; model_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wr_data = 8'(8'h21 + i); wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    tests++; if (count !== 5'd15) begin fails++; $display("FAIL wrap_count15 got %0d want 15", count); end
    tests++; if (full !== 1'b0)   begin fails++; $display("FAIL wrap_not_full got %b want 0", full); end
    base = cap_q.size();
    busy_force = 1'b0; model_en = 1'b1;
    @(negedge clk);                    // WAIT_DONE -> IDLE
    wr_data = 8'h30; wr_en = 1'b1;
    @(negedge clk);                    // pop and write on the same edge
    wr_en = 1'b0;
    tests++; if (count !== 5'd15)    begin fails++; $display("FAIL wrap_same_edge_count got %0d want 15", count); end
    tests++; if (overflow !== 1'b0)  begin fails++; $display("FAIL wrap_same_edge_ovf got %b want 0", overflow); end
    tests++; if (tx_start !== 1'b1)  begin fails++; $display("FAIL wrap_same_edge_start got %b want 1", tx_start); end
    tests++; if (tx_data !== 8'h21)  begin fails++; $display("FAIL wrap_same_edge_data got %h want 21", tx_data); end
    c = 0;
    while (cap_q.size() - base < 16 && c < 400) begin @(negedge clk); c++; end
    repeat (16) @(negedge clk);
    tests++; if (cap_q.size() - base !== 16) begin fails++; $display("FAIL wrap_starts got %0d want 16", cap_q.size() - base); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b want 1", empty); end
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(8'h21 + i);
      if (base + i < cap_q.size()) begin
        tests++;
        if (cap_q[base + i] !== exp_b) begin fails++; $display("FAIL wrap_byte[%0d] got %h want %h", i, cap_q[base + i], exp_b); end
      end
    end
  endtask

  task automatic test_timeout();
    int unsigned base = cap_q.size();
    logic [9:0]  seen = '0;
    logic [7:0]  d1 = '0;
    logic [7:0]  d7 = '0;
    model_en = 1'b0; busy_force = 1'b0;
    wr_data = 8'hA5; wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) wr_data = 8'h5A;
      if (i == 1) wr_en = 1'b0;
      seen[i] = tx_start;
      if (i == 1) d1 = tx_data;
      if (i == 7) d7 = tx_data;
    end
    // START after edge k+1, four WAIT_BUSY cycles, IDLE, next START after k+7
    tests++; if (seen !== 10'h082) begin fails++; $display("FAIL timeout_start_pattern got %b want 0010000010", seen); end
    tests++; if (d1 !== 8'hA5) begin fails++; $display("FAIL timeout_first_data got %h want a5", d1); end
    tests++; if (d7 !== 8'h5A) begin fails++; $display("FAIL timeout_second_data got %h want 5a", d7); end
    repeat (10) @(negedge clk);
    tests++; if (cap_q.size() - base !== 2) begin fails++; $display("FAIL timeout_starts got %0d want 2", cap_q.size() - base); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL timeout_empty got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    int unsigned base;
    int unsigned starts = 0;
    int unsigned nonzero = 0;
    model_en = 1'b1; busy_force = 1'b0;
    repeat (4) @(negedge clk);
    base = cap_q.size();
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h40 + i); wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    tests++; if (count !== 5'd5)  begin fails++; $display("FAIL mid_count got %0d want 5", count); end
    tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", tx_busy); end
    tests++; if (cap_q.size() - base !== 1) begin fails++; $display("FAIL mid_starts got %0d want 1", cap_q.size() - base); end
    #2 rst = 1'b1;
    #1;
    tests++; if (count !== '0)      begin fails++; $display("FAIL async_count got %0d want 0", count); end
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL async_empty got %b want 1", empty); end
    tests++; if (full !== 1'b0)     begin fails++; $display("FAIL async_full got %b want 0", full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL async_overflow got %b want 0", overflow); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL async_tx_start got %b want 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL async_tx_data got %h want 00", tx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_start) starts++;
      if (count != 0) nonzero++;
    end
    tests++; if (starts !== 0)  begin fails++; $display("FAIL post_reset_starts got %0d want 0", starts); end
    tests++; if (nonzero !== 0) begin fails++; $display("FAIL post_reset_count got %0d nonzero cycles want 0", nonzero); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_drain();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
